mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core; sequences the shared PC/IR/regfile/ALU/unified-memory datapath over IF/ID/EX/MEM/WB.
- Consumes opcode/funct fields split from the IR by the field-extraction logic, plus the ALU zero flag; drives all datapath strobes and muxes.
- One memory port shared between instruction fetch and data access via req/ready handshake.

Parameters:
- RESET_STATE_FETCH, 1, 1: leave reset into FETCH; 0: leave reset into HALT until go pulses.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- go  in  1  start pulse (only used when RESET_STATE_FETCH=0)
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU result==0
- mem_ready  in  1  memory completes transfer this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1=store, 0=load/fetch
- iord  out  1  memory address: 0=PC, 1=ALUOut
- ir_we  out  1  latch IR
- pc_we  out  1  write PC
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump imm26, 3=rs
- reg_we  out  1  regfile write
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- wb_src  out  2  0=ALUOut, 1=MDR, 2=PC(link)
- alu_src_b  out  2  0=rt, 1=zext imm16, 2=sext imm16
- alu_op  out  3  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 SLL,6 LUI
- illegal  out  1  sticky undefined-instruction flag
- state_o  out  3  current state (debug)

Behaviour:
- States: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- rst=1: state<=FETCH (or HALT), illegal<=0, instr class cleared. All strobes (mem_req, ir_we, pc_we, reg_we, mem_we) forced 0 in any cycle rst=1. Reset mid-access drops mem_req immediately; no completion.
- Outputs: combinational from registered state + latched class. Mux selects are 0 when unused.
- HALT: no strobes; go=1 -> FETCH.
- FETCH: mem_req=1, iord=0, mem_we=0. Held until mem_ready=1; that cycle ir_we=1, pc_we=1, pc_src=0 -> DECODE. mem_ready=0 -> stay.
- DECODE: classify opcode/funct into a registered class.
  - j: pc_we, pc_src=2 -> FETCH.
  - jal: pc_we, pc_src=2, reg_we, reg_dst=2, wb_src=2 (old PC+4 held by datapath) -> FETCH.
  - jr (R, funct 001000): pc_we, pc_src=3 -> FETCH.
  - Undefined -> TRAP. Others -> EXEC.
- Encodings: R=000000 with addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000, jr 001000; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
- EXEC:
  - R: alu_op from funct, alu_src_b=0 -> WB.
  - ori: OR, src_b=1 -> WB.
  - lui: LUI, src_b=1 -> WB.
  - lw/sw: ADD, src_b=2 -> MEM.
  - beq: SUB, src_b=0; pc_we=alu_zero, pc_src=1 -> FETCH.
- MEM: mem_req=1, iord=1, mem_we=(sw). Hold until mem_ready. sw -> FETCH; lw -> WB.
- WB: reg_we=1. R: reg_dst=1, wb_src=0. ori/lui: reg_dst=0, wb_src=0. lw: reg_dst=0, wb_src=1. -> FETCH.
- TRAP: illegal=1, no strobes, stays until rst.
- Zero-wait cycles per instruction: j/jal/jr 2, beq 3, R/ori/lui/sw 4, lw 5. Each wait cycle adds 1.
- mem_ready while mem_req=0: ignored.

Optional Feature:
- MC_PERF_CNT_EN defined: adds outputs retired (32b) and cycles (32b).
  - cycles increments each non-reset cycle with state not HALT/TRAP.
  - retired increments on each transition into FETCH from DECODE/EXEC/MEM/WB.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and logic absent.

Decomposition:
- Package mc_pkg: state enum, opcode/funct constants, alu_op / pc_src / reg_dst / wb_src / alu_src_b codes, instr-class enum.
- One natural sub-module, mc_idecode: combinational opcode/funct -> class + legal flag, used in DECODE.

Test Plan:
- addu, mem_ready always 1: states 1,2,3,5,1; reg_we=1 in cycle 4 with reg_dst=1, alu_op=0; pc_we only in cycle 1.
- lw, mem_ready delayed 3 cycles in MEM: mem_req/iord=1 held 4 cycles; then WB with wb_src=1, reg_dst=0; total 8 cycles.
- beq with alu_zero=1: pc_we=1, pc_src=1 in EXEC; with alu_zero=0: pc_we=0; both return to FETCH in 3 cycles.
- jal: completes in 2 cycles; DECODE shows pc_src=2, reg_we=1, reg_dst=2, wb_src=2.
- opcode 111111: TRAP, illegal=1 sticky, no strobes for 20 cycles; rst -> FETCH, illegal=0.
- rst asserted mid-FETCH with mem_ready=0: mem_req=0 that cycle, state_o=1 next cycle; MC_PERF_CNT_EN build: counters read 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
// Holds the state encoding, opcode/funct constants, datapath mux select codes,
// the instruction-class enum latched in DECODE, and small class helpers.
package mc_pkg;

  typedef enum logic [2:0] {
    StHalt   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  // One class per supported instruction so EXEC/WB need no re-decode.
  typedef enum logic [3:0] {
    ClsNone,
    ClsAddu,
    ClsSubu,
    ClsAnd,
    ClsOr,
    ClsSlt,
    ClsSll,
    ClsJr,
    ClsOri,
    ClsLui,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsJ,
    ClsJal,
    ClsIllegal
  } cls_e;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4,
    AluSll = 3'd5,
    AluLui = 3'd6
  } alu_op_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  // pc_src
  localparam logic [1:0] PcSrcSeq    = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcReg    = 2'd3;

  // reg_dst
  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  // wb_src
  localparam logic [1:0] WbSrcAlu = 2'd0;
  localparam logic [1:0] WbSrcMdr = 2'd1;
  localparam logic [1:0] WbSrcPc  = 2'd2;

  // alu_src_b
  localparam logic [1:0] SrcBRt   = 2'd0;
  localparam logic [1:0] SrcBZext = 2'd1;
  localparam logic [1:0] SrcBSext = 2'd2;

  // R-type ALU instructions that go through EXEC and WB.
  function automatic logic is_r_alu(input cls_e cls);
    return cls inside {ClsAddu, ClsSubu, ClsAnd, ClsOr, ClsSlt, ClsSll};
  endfunction

  function automatic alu_op_e r_alu_op(input cls_e cls);
    alu_op_e op;
    op = AluAdd;
    unique case (cls)
      ClsSubu: op = AluSub;
      ClsAnd:  op = AluAnd;
      ClsOr:   op = AluOr;
      ClsSlt:  op = AluSlt;
      ClsSll:  op = AluSll;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_idecode.sv
// Combinational instruction classifier.
// Ports:
//   opcode_i  IR[31:26]
//   funct_i   IR[5:0], only meaningful for R-type
//   cls_o     instruction class (ClsIllegal for any undefined encoding)
//   legal_o   1 when the encoding is one the core supports
module mc_idecode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o = ClsIllegal;
    unique case (opcode_i)
      OpRType: begin
        unique case (funct_i)
          FnAddu:  cls_o = ClsAddu;
          FnSubu:  cls_o = ClsSubu;
          FnAnd:   cls_o = ClsAnd;
          FnOr:    cls_o = ClsOr;
          FnSlt:   cls_o = ClsSlt;
          FnSll:   cls_o = ClsSll;
          FnJr:    cls_o = ClsJr;
          default: cls_o = ClsIllegal;
        endcase
      end
      OpOri:   cls_o = ClsOri;
      OpLui:   cls_o = ClsLui;
      OpLw:    cls_o = ClsLw;
      OpSw:    cls_o = ClsSw;
      OpBeq:   cls_o = ClsBeq;
      OpJ:     cls_o = ClsJ;
      OpJal:   cls_o = ClsJal;
      default: cls_o = ClsIllegal;
    endcase
  end

  assign legal_o = (cls_o != ClsIllegal);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS core. Sequences the shared PC/IR/
// regfile/ALU/unified-memory datapath through FETCH/DECODE/EXEC/MEM/WB.
//
// Parameter RESET_STATE_FETCH: 1 leaves reset into FETCH, 0 into HALT (wait go).
// Optional build macro MC_PERF_CNT_EN adds retired/cycles performance counters.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go                start pulse out of HALT
//   opcode, funct     IR fields; held stable by the datapath after fetch
//   alu_zero          ALU result == 0 (beq)
//   mem_ready         shared memory port completes the transfer this cycle
//   mem_req, mem_we   memory request / store enable
//   iord              memory address select: 0=PC, 1=ALUOut
//   ir_we, pc_we      IR and PC write strobes
//   pc_src            0=PC+4, 1=branch target, 2=jump imm26, 3=rs
//   reg_we, reg_dst   regfile write strobe, dest select 0=rt 1=rd 2=r31
//   wb_src            0=ALUOut, 1=MDR, 2=PC(link)
//   alu_src_b, alu_op ALU B operand select and operation
//   illegal           sticky undefined-instruction flag
//   state_o           current state (debug)
//   retired, cycles   (MC_PERF_CNT_EN only) 32-bit wrapping counters
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [2:0] state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] cycles
`endif
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  logic   illegal_q, illegal_d;

  cls_e   dec_cls;
  logic   dec_legal;

  mc_idecode u_idecode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE_FETCH ? StFetch : StHalt;
      cls_q     <= ClsNone;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    unique case (state_q)
      StHalt: begin
        if (go) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        cls_d = dec_cls;
        if (!dec_legal) begin
          state_d = StTrap;
        end else if (dec_cls inside {ClsJ, ClsJal, ClsJr}) begin
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsLw, ClsSw: state_d = StMem;
          ClsBeq:       state_d = StFetch;
          default:      state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem_ready) state_d = (cls_q == ClsSw) ? StFetch : StWb;
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      // Unreachable encoding: park in TRAP so the corruption is visible.
      default: state_d = StTrap;
    endcase
    illegal_d = illegal_q | (state_d == StTrap);
  end

  // Output logic
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PcSrcSeq;
    reg_we    = 1'b0;
    reg_dst   = RegDstRt;
    wb_src    = WbSrcAlu;
    alu_src_b = SrcBRt;
    alu_op    = AluAdd;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      StDecode: begin
        // Jumps finish here, so they use the live decode of the held IR.
        unique case (dec_cls)
          ClsJ: begin
            pc_we  = 1'b1;
            pc_src = PcSrcJump;
          end
          ClsJal: begin
            pc_we   = 1'b1;
            pc_src  = PcSrcJump;
            reg_we  = 1'b1;
            reg_dst = RegDstRa;
            wb_src  = WbSrcPc;
          end
          ClsJr: begin
            pc_we  = 1'b1;
            pc_src = PcSrcReg;
          end
          default: ;
        endcase
      end
      StExec: begin
        if (is_r_alu(cls_q)) begin
          alu_op = r_alu_op(cls_q);
        end else begin
          unique case (cls_q)
            ClsOri: begin
              alu_op    = AluOr;
              alu_src_b = SrcBZext;
            end
            ClsLui: begin
              alu_op    = AluLui;
              alu_src_b = SrcBZext;
            end
            ClsLw, ClsSw: begin
              alu_op    = AluAdd;
              alu_src_b = SrcBSext;
            end
            ClsBeq: begin
              alu_op = AluSub;
              pc_we  = alu_zero;
              pc_src = PcSrcBranch;
            end
            default: ;
          endcase
        end
      end
      StMem: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls_q == ClsSw);
      end
      StWb: begin
        reg_we = 1'b1;
        if (is_r_alu(cls_q)) begin
          reg_dst = RegDstRd;
        end else if (cls_q == ClsLw) begin
          wb_src = WbSrcMdr;
        end
      end
      default: ;
    endcase
    // Reset kills any in-flight access in the same cycle.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d  = cycles_q;
    retired_d = retired_q;
    if (state_q != StHalt && state_q != StTrap) cycles_d = cycles_q + 32'd1;
    if (state_d == StFetch && (state_q inside {StDecode, StExec, StMem, StWb})) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign retired = retired_q;
  assign cycles  = cycles_q;
`endif

endmodule
